// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used across the memory hierarchy.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

endpackage

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the I-cache and D-cache.
// One transaction at a time; a grant is held until L2 responds.
module l1_l2_arbiter
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     rst_n,

    input  logic     i_read,
    input  lc3b_word i_address,
    output logic     i_resp,
    output lc3b_line i_rdata,

    input  logic     d_read,
    input  logic     d_write,
    input  lc3b_word d_address,
    input  lc3b_line d_wdata,
    output logic     d_resp,
    output lc3b_line d_rdata,

    output logic     L2_read,
    output logic     L2_write,
    output lc3b_word L2_address,
    output lc3b_line L2_wdata,
    input  logic     L2_resp,
    input  lc3b_line L2_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t state;
    logic   last_grant;
    logic   d_req;

    assign d_req = d_read | d_write;

    // Reset leaves last_grant at D so the first contested request goes to the I-cache.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_read && (!d_req || last_grant == GRANT_D)) begin
                        state      <= SERVE_I;
                        last_grant <= GRANT_I;
                    end else if (d_req) begin
                        state      <= SERVE_D;
                        last_grant <= GRANT_D;
                    end
                end
                SERVE_I: if (L2_resp) state <= IDLE;
                SERVE_D: if (L2_resp) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign i_rdata = L2_rdata;
    assign d_rdata = L2_rdata;

    // Client request fields pass straight through; clients hold them stable until resp.
    always_comb begin
        L2_read    = 1'b0;
        L2_write   = 1'b0;
        L2_address = '0;
        L2_wdata   = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        unique case (state)
            SERVE_I: begin
                L2_read    = 1'b1;
                L2_address = i_address;
                i_resp     = L2_resp;
            end
            SERVE_D: begin
                L2_read    = d_read;
                L2_write   = d_write;
                L2_address = d_address;
                L2_wdata   = d_wdata;
                d_resp     = L2_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Randomized scoreboard bench for l1_l2_arbiter: a round-robin merge model predicts
// the order of L2 transactions and a negedge monitor checks what the arbiter presents.
module tb_l1_l2_arbiter;
    import lc3b_types::*;

    typedef struct {
        logic     is_d;
        logic     rd;
        logic     wr;
        lc3b_word addr;
        lc3b_line wdata;
    } txn_t;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     i_read;
    lc3b_word i_address;
    logic     i_resp;
    lc3b_line i_rdata;
    logic     d_read;
    logic     d_write;
    lc3b_word d_address;
    lc3b_line d_wdata;
    logic     d_resp;
    lc3b_line d_rdata;
    logic     L2_read;
    logic     L2_write;
    lc3b_word L2_address;
    lc3b_line L2_wdata;
    logic     L2_resp;
    lc3b_line L2_rdata;

    txn_t exp_q[$];
    txn_t i_list[$];
    txn_t d_list[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic model_last_d;
    logic mon_active;
    logic mon_just_ended;
    txn_t mon_cur;
    logic i_resp_seen;
    logic d_resp_seen;
    int   resp_wait;

    l1_l2_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .L2_read(L2_read), .L2_write(L2_write), .L2_address(L2_address), .L2_wdata(L2_wdata),
        .L2_resp(L2_resp), .L2_rdata(L2_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic lc3b_line rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic txn_t makeI(input lc3b_word a);
        txn_t t;
        t.is_d = 1'b0; t.rd = 1'b1; t.wr = 1'b0; t.addr = a; t.wdata = '0;
        return t;
    endfunction

    function automatic txn_t makeD(input logic wr, input lc3b_word a, input lc3b_line w);
        txn_t t;
        t.is_d = 1'b1; t.rd = ~wr; t.wr = wr; t.addr = a; t.wdata = w;
        return t;
    endfunction

    // Monitor: pops the next expected transaction when the L2 port becomes busy.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active     = 1'b0;
            mon_just_ended = 1'b0;
            checkOutput("reset_L2_read", L2_read, 0);
            checkOutput("reset_L2_write", L2_write, 0);
            checkOutput("reset_L2_address", L2_address, 0);
            checkOutput("reset_resp", {i_resp, d_resp}, 0);
        end else begin
            checkOutput("i_rdata", i_rdata, L2_rdata);
            checkOutput("d_rdata", d_rdata, L2_rdata);
            if (!mon_active && !mon_just_ended && (L2_read || L2_write)) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_txn", {L2_read, L2_write, L2_address}, 0);
                end else begin
                    mon_cur    = exp_q.pop_front();
                    mon_active = 1'b1;
                end
            end
            if (mon_active) begin
                checkOutput("L2_read", L2_read, mon_cur.rd);
                checkOutput("L2_write", L2_write, mon_cur.wr);
                checkOutput("L2_address", L2_address, mon_cur.addr);
                checkOutput("L2_wdata", L2_wdata, mon_cur.wdata);
                checkOutput("i_resp", i_resp, L2_resp & ~mon_cur.is_d);
                checkOutput("d_resp", d_resp, L2_resp & mon_cur.is_d);
                if (L2_resp) begin
                    mon_active     = 1'b0;
                    mon_just_ended = 1'b1;
                end
            end else begin
                checkOutput("idle_strobes", {L2_read, L2_write}, 0);
                checkOutput("idle_address", L2_address, 0);
                checkOutput("idle_wdata", L2_wdata, 0);
                checkOutput("idle_resp", {i_resp, d_resp}, 0);
                mon_just_ended = 1'b0;
            end
        end
    end

    task automatic driveClients();
        i_read    = (i_list.size() > 0);
        i_address = (i_list.size() > 0) ? i_list[0].addr : '0;
        d_read    = (d_list.size() > 0) ? d_list[0].rd : 1'b0;
        d_write   = (d_list.size() > 0) ? d_list[0].wr : 1'b0;
        d_address = (d_list.size() > 0) ? d_list[0].addr : '0;
        d_wdata   = (d_list.size() > 0) ? d_list[0].wdata : '0;
    endtask

    task automatic responderStep();
        L2_rdata = rand_line();
        if (L2_resp) begin
            L2_resp   = 1'b0;
            resp_wait = -1;
        end else if (L2_read || L2_write) begin
            if (resp_wait < 0) resp_wait = int'($urandom_range(0, 3));
            if (resp_wait == 0) L2_resp = 1'b1;
            else resp_wait--;
        end
    endtask

    // Model: while both clients have work the grants alternate, starting opposite the last grant.
    task automatic predictOrder();
        int a = 0;
        int b = 0;
        logic take_d;
        while (a < i_list.size() || b < d_list.size()) begin
            if (a < i_list.size() && b < d_list.size()) take_d = ~model_last_d;
            else take_d = (b < d_list.size());
            if (take_d) begin exp_q.push_back(d_list[b]); b++; end
            else begin exp_q.push_back(i_list[a]); a++; end
            model_last_d = take_d;
        end
    endtask

    // Both clients raise their first requests together and re-request right after each resp.
    task automatic applyStimulus();
        int cycles = 0;
        predictOrder();
        resp_wait = -1;
        @(posedge clk); #1;
        driveClients();
        i_resp_seen = 1'b0;
        d_resp_seen = 1'b0;
        while ((i_list.size() > 0 || d_list.size() > 0) && cycles < 300) begin
            @(posedge clk); #1;
            cycles++;
            if (i_resp_seen) void'(i_list.pop_front());
            if (d_resp_seen) void'(d_list.pop_front());
            driveClients();
            responderStep();
            #1;
            i_resp_seen = i_resp;
            d_resp_seen = d_resp;
        end
        if (cycles >= 300) begin
            checkOutput("batch_timeout", cycles, 0);
            i_list.delete();
            d_list.delete();
            driveClients();
            L2_resp = 1'b0;
        end
        @(posedge clk); #1;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic idleRespPulse();
        @(posedge clk); #1;
        L2_resp = 1'b1;
        @(posedge clk); #1;
        L2_resp = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; L2_resp = 1'b0; L2_rdata = '0;
        i_list.delete(); d_list.delete();
        driveClients();
        mon_active = 1'b0; mon_just_ended = 1'b0;
        model_last_d = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        i_list.push_back(makeI(16'h1230));
        applyStimulus();

        i_list.push_back(makeI(16'h2000));
        d_list.push_back(makeD(1'b0, 16'h3000, rand_line()));
        applyStimulus();

        d_list.push_back(makeD(1'b1, 16'h4440, {16{8'hA5}}));
        applyStimulus();

        for (int k = 0; k < 3; k++) begin
            i_list.push_back(makeI(16'h5000 + 16'(k)));
            d_list.push_back(makeD(k[0], 16'h6000 + 16'(k), rand_line()));
        end
        applyStimulus();

        idleRespPulse();

        for (int n = 0; n < 25; n++) begin
            int ni = int'($urandom_range(0, 3));
            int nd = int'($urandom_range(0, 3));
            for (int k = 0; k < ni; k++) i_list.push_back(makeI(16'($urandom)));
            for (int k = 0; k < nd; k++) d_list.push_back(makeD(1'($urandom), 16'($urandom), rand_line()));
            applyStimulus();
            if ($urandom_range(0, 3) == 0) idleRespPulse();
        end

        d_list.push_back(makeD(1'b0, 16'h7777, rand_line()));
        exp_q.push_back(d_list[0]);
        @(posedge clk); #1;
        driveClients();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_L2_read", L2_read, 0);
        checkOutput("async_reset_L2_address", L2_address, 0);
        checkOutput("async_reset_d_resp", d_resp, 0);
        d_list.delete();
        exp_q.delete();
        driveClients();
        model_last_d = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        i_list.push_back(makeI(16'h8100));
        d_list.push_back(makeD(1'b1, 16'h8200, rand_line()));
        applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/l1_l2_arbiter.md
L1_L2_ARBITER -- requirements
Module: l1_l2_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous reset, active low.
REQ-002 SHALL have: i_read  input  1  I-cache line-fill request; i_address  input  16 (lc3b_word)  I-cache line address.
REQ-003 SHALL have: i_resp  output  1  I-cache request complete; i_rdata  output  128 (lc3b_line)  fill data to I-cache.
REQ-004 SHALL have: d_read  input  1  D-cache fill request; d_write  input  1  D-cache writeback request; d_address  input  16  line address; d_wdata  input  128  writeback line.
REQ-005 SHALL have: d_resp  output  1  D-cache request complete; d_rdata  output  128  fill data to D-cache.
REQ-006 SHALL have: L2_read  output  1; L2_write  output  1; L2_address  output  16; L2_wdata  output  128 (all toward L2); L2_resp  input  1; L2_rdata  input  128 (from L2).

Function
REQ-007 SHALL implement FSM states IDLE, SERVE_I, SERVE_D in a registered state variable.
REQ-008 IDLE: all L2 and client strobes SHALL be 0; L2_address/L2_wdata SHALL be 0.
REQ-009 IDLE -> SERVE_I when i_read=1 and no D request (d_read|d_write)=0, or both requesting and last_grant=D.
REQ-010 IDLE -> SERVE_D when D request=1 and i_read=0, or both requesting and last_grant=I.
REQ-011 last_grant SHALL be a 1-bit register updated on every IDLE->SERVE_x transition to the client granted.
REQ-012 SERVE_I: L2_read=1, L2_write=0, L2_address=i_address, L2_wdata=0.
REQ-013 SERVE_D: L2_read=d_read, L2_write=d_write, L2_address=d_address, L2_wdata=d_wdata.
REQ-014 i_rdata and d_rdata SHALL both be driven from L2_rdata combinationally at all times.
REQ-015 i_resp=L2_resp only in SERVE_I, else 0; d_resp=L2_resp only in SERVE_D, else 0.
REQ-016 SERVE_x -> IDLE on the cycle L2_resp=1; otherwise SHALL remain in SERVE_x.
REQ-017 Grant SHALL NOT be revoked before L2_resp, even if the served client drops its request; no abort path.
REQ-018 Latency: request sampled in IDLE at edge N SHALL produce L2 strobe in cycle N+1; L2_resp in cycle M SHALL give IDLE in M+1, next grant earliest M+2.
REQ-019 Clients SHALL hold request, address and wdata stable until their resp; arbiter SHALL NOT register them.
REQ-020 d_read and d_write both 1 is illegal; arbiter SHALL pass both through unmodified (no checking).
REQ-021 L2_resp while IDLE SHALL be ignored (no client resp, no state change).
REQ-022 Tie-break SHALL be round-robin so neither client waits more than one other transaction under continuous contention.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=IDLE and last_grant=D, regardless of in-flight transaction.
REQ-024 During and immediately after reset all outputs SHALL be 0 except rdata pass-through.
REQ-025 After rst_n rises, the first simultaneous request SHALL be granted to the I-cache.

Structure
REQ-026 lc3b_word and lc3b_line SHALL come from shared package lc3b_types; no new package types added.
REQ-027 FSM state enum and last_grant encoding SHALL be local to the module.
REQ-028 Single module, no sub-modules; instantiated between the L1 caches and L2_cache in the memory hierarchy top level.

Verification
REQ-029 Reset, then i_read=1, d idle, i_address=0x1230, L2_resp at 3rd serve cycle -> L2_read=1, L2_address=0x1230, i_resp=1 one cycle, d_resp=0.
REQ-030 After reset, i_read and d_read asserted same cycle -> I served first, then D; L2_address shows I addr then D addr, IDLE cycle between.
REQ-031 d_write=1, d_address=0x4440, d_wdata=0xA5..A5 -> L2_write=1, L2_wdata passes through, d_resp on L2_resp, L2_read=0.
REQ-032 Both clients requesting continuously for 6 transactions -> grants alternate I,D,I,D,I,D.
REQ-033 rst_n low mid SERVE_D -> all strobes 0 immediately (asynchronous), state IDLE, next tie goes to I.
REQ-034 L2_resp pulsed while IDLE -> i_resp=d_resp=0, state stays IDLE.
